// File: rtl/pmu_multi_domain.sv
// Power management unit for the gated clock domains of the sail core.
// Each channel has an idle-timeout / powerup-settle FSM. A global sleep latch
// counts qualifying falling edges of the data-memory stall and then holds every
// non-pinned channel off until wake_req.
module pmu_multi_domain #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned IDLE_W      = 8,
    parameter int unsigned IDLE_CYCLES = 200,
    parameter int unsigned PWRUP_DELAY = 4,
    parameter logic [31:0] SLEEP_SP    = 32'h1000,
    parameter int unsigned MATCH_COUNT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_mem_stall_sig,
    input  logic [31:0]     rdsp,
    input  logic [N_CH-1:0] activity,
    input  logic [N_CH-1:0] pin_on,
    input  logic            wake_req,
    output logic [N_CH-1:0] clk_enable,
    output logic [N_CH-1:0] clk_powerup,
    output logic            sleep_active,
    output logic [3:0]      match_cnt
);

    typedef enum logic [1:0] {StOn, StIdle, StOff, StWake} ch_state_e;

    localparam logic [IDLE_W-1:0] IdleLimit = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] WakeLimit = IDLE_W'(PWRUP_DELAY - 1);
    localparam logic [IDLE_W-1:0] CntOne    = IDLE_W'(1);
    localparam logic [3:0]        MatchMax  = 4'(MATCH_COUNT);

    ch_state_e         state_q [N_CH];
    ch_state_e         state_d [N_CH];
    logic [IDLE_W-1:0] cnt_q   [N_CH];
    logic [IDLE_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]   clk_enable_q, clk_enable_d;
    logic [N_CH-1:0]   clk_powerup_q, clk_powerup_d;
    logic              stall_q;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic              sleep_q, sleep_d;
    logic              fall;
    logic [N_CH-1:0]   gs;

    // Falling edge of the stall seen one cycle late; pinned channels ignore sleep.
    assign fall = stall_q & ~data_mem_stall_sig;
    assign gs   = {N_CH{sleep_q}} & ~pin_on;

    // Sleep latch and saturating match counter; wake_req overrides everything.
    always_comb begin
        match_cnt_d = match_cnt_q;
        sleep_d     = sleep_q;
        if (wake_req) begin
            match_cnt_d = 4'd0;
            sleep_d     = 1'b0;
        end else begin
            if (match_cnt_q == MatchMax) begin
                sleep_d = 1'b1;
            end
            if (fall && (rdsp == SLEEP_SP) && (match_cnt_q < MatchMax)) begin
                match_cnt_d = match_cnt_q + 4'd1;
            end
        end
    end

    // Per-channel FSM next state, counter and next registered outputs.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StOn: begin
                    cnt_d[i] = '0;
                    if (gs[i]) begin
                        state_d[i] = StOff;
                    end else if (!activity[i] && !pin_on[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = CntOne;
                    end
                end
                StIdle: begin
                    if (activity[i] || pin_on[i]) begin
                        state_d[i] = StOn;
                        cnt_d[i]   = '0;
                    end else if (gs[i] || (cnt_q[i] == IdleLimit)) begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StOff: begin
                    cnt_d[i] = '0;
                    if ((activity[i] || pin_on[i]) && !gs[i]) begin
                        state_d[i] = StWake;
                    end
                end
                StWake: begin
                    if (gs[i]) begin
                        state_d[i] = StOff;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == WakeLimit) begin
                        state_d[i] = StOn;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StOn;
                    cnt_d[i]   = '0;
                end
            endcase
            clk_enable_d[i]  = (state_d[i] == StOn) || (state_d[i] == StIdle);
            clk_powerup_d[i] = (state_d[i] != StOff);
        end
    end

    // All state; reset puts every domain straight into ON with clocks running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= StOn;
                cnt_q[i]   <= '0;
            end
            clk_enable_q  <= '1;
            clk_powerup_q <= '1;
            stall_q       <= 1'b1;
            match_cnt_q   <= 4'd0;
            sleep_q       <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clk_enable_q  <= clk_enable_d;
            clk_powerup_q <= clk_powerup_d;
            stall_q       <= data_mem_stall_sig;
            match_cnt_q   <= match_cnt_d;
            sleep_q       <= sleep_d;
        end
    end

    assign clk_enable   = clk_enable_q;
    assign clk_powerup  = clk_powerup_q;
    assign sleep_active = sleep_q;
    assign match_cnt    = match_cnt_q;

endmodule

// File: tb/tb_pmu_multi_domain.sv
// Directed bench for pmu_multi_domain with default parameters.
module tb_pmu_multi_domain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] rdsp;
    logic [1:0]  activity;
    logic [1:0]  pin_on;
    logic        wake_req;
    logic [1:0]  clk_enable;
    logic [1:0]  clk_powerup;
    logic        sleep_active;
    logic [3:0]  match_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmu_multi_domain dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_mem_stall_sig (stall),
        .rdsp               (rdsp),
        .activity           (activity),
        .pin_on             (pin_on),
        .wake_req           (wake_req),
        .clk_enable         (clk_enable),
        .clk_powerup        (clk_powerup),
        .sleep_active       (sleep_active),
        .match_cnt          (match_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Enable must never be high while the oscillator is powered down.
    always @(negedge clk) begin
        checks++;
        assert ((clk_enable & ~clk_powerup) === 2'b00) else begin
            errors++;
            $error("FAIL en_implies_pu: observed en=%b pu=%b expected en&~pu=00",
                   clk_enable, clk_powerup);
        end
    end

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b1;
        rdsp     = 32'h0;
        activity = 2'b00;
        pin_on   = 2'b00;
        wake_req = 1'b0;
        #12;
        check("rst_en", clk_enable, 2'b11);
        check("rst_pu", clk_powerup, 2'b11);
        check("rst_match", match_cnt, 4'd0);
        check("rst_sleep", sleep_active, 1'b0);
        #8 rst_n = 1'b1;

        // 1: idle timeout from reset
        step(1);
        check("t1_en_c1", clk_enable, 2'b11);
        step(199);
        check("t1_en_c200", clk_enable, 2'b11);
        check("t1_pu_c200", clk_powerup, 2'b11);
        step(1);
        check("t1_en_c201", clk_enable, 2'b00);
        check("t1_pu_c201", clk_powerup, 2'b00);

        // 2: one-cycle activity pulse wakes channel 0
        activity = 2'b01;
        step(1);
        activity = 2'b00;
        check("t2_pu_p1", clk_powerup, 2'b01);
        check("t2_en_p1", clk_enable, 2'b00);
        step(3);
        check("t2_en_p4", clk_enable, 2'b00);
        step(1);
        check("t2_en_p5", clk_enable, 2'b01);

        // pin channel 1 on: it wakes through WAKE like any other channel
        pin_on = 2'b10;
        step(1);
        check("pin_pu", clk_powerup, 2'b11);
        check("pin_en_wake", clk_enable, 2'b01);
        step(4);
        check("pin_en_on", clk_enable, 2'b11);

        // 3: two qualifying falls enter sleep
        activity = 2'b01;
        rdsp     = 32'h1000;
        stall    = 1'b0;
        step(1);
        check("t3_match1", match_cnt, 4'd1);
        check("t3_sleep_a", sleep_active, 1'b0);
        stall = 1'b1;
        step(1);
        check("t3_match1_hold", match_cnt, 4'd1);
        stall = 1'b0;
        step(1);
        check("t3_match2", match_cnt, 4'd2);
        check("t3_sleep_b", sleep_active, 1'b0);
        stall = 1'b1;
        step(1);
        check("t3_sleep_set", sleep_active, 1'b1);
        check("t3_en_pre", clk_enable, 2'b11);
        step(1);
        check("t3_en_off", clk_enable, 2'b10);
        check("t3_pu_off", clk_powerup, 2'b10);
        stall = 1'b0;
        step(1);
        check("t3_match_sat", match_cnt, 4'd2);
        stall = 1'b1;
        step(1);

        // 5: activity ignored while sleeping, pinned channel stays on
        step(3);
        check("t5_en_sleep", clk_enable, 2'b10);
        check("t5_pu_sleep", clk_powerup, 2'b10);
        wake_req = 1'b1;
        stall    = 1'b0;
        step(1);
        wake_req = 1'b0;
        stall    = 1'b1;
        check("t5_wake_match", match_cnt, 4'd0);
        check("t5_wake_sleep", sleep_active, 1'b0);
        check("t5_wake_en", clk_enable, 2'b10);
        step(1);
        check("t5_wake_pu", clk_powerup, 2'b11);
        check("t5_wake_en1", clk_enable, 2'b10);
        step(3);
        check("t5_wake_en4", clk_enable, 2'b10);
        step(1);
        check("t5_on", clk_enable, 2'b11);

        // 4: non-matching stack pointer, then wake beats a qualifying fall
        rdsp  = 32'h0FFC;
        stall = 1'b0;
        step(1);
        check("t4_nomatch_a", match_cnt, 4'd0);
        stall = 1'b1;
        step(1);
        stall = 1'b0;
        step(1);
        check("t4_nomatch_b", match_cnt, 4'd0);
        stall = 1'b1;
        step(1);
        rdsp     = 32'h1000;
        stall    = 1'b0;
        wake_req = 1'b1;
        step(1);
        check("t4_wake_wins", match_cnt, 4'd0);
        check("t4_wake_sleep", sleep_active, 1'b0);
        wake_req = 1'b0;
        stall    = 1'b1;
        step(1);
        check("t4_after", match_cnt, 4'd0);

        // idle timeout measured from the last activity cycle
        activity = 2'b00;
        step(200);
        check("idle_en_200", clk_enable, 2'b11);
        step(1);
        check("idle_en_201", clk_enable, 2'b10);
        check("idle_pu_201", clk_powerup, 2'b10);

        // 6: reset in WAKE with counter 2
        activity = 2'b01;
        stall    = 1'b0;
        step(1);
        activity = 2'b00;
        stall    = 1'b1;
        check("t6_wake_pu", clk_powerup, 2'b11);
        check("t6_match", match_cnt, 4'd1);
        step(2);
        check("t6_wake_en", clk_enable, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", clk_enable, 2'b11);
        check("t6_rst_pu", clk_powerup, 2'b11);
        check("t6_rst_match", match_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_rel_en", clk_enable, 2'b11);
        step(3);
        check("t6_on_en", clk_enable, 2'b11);
        check("t6_on_match", match_cnt, 4'd0);
        check("t6_on_sleep", sleep_active, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
